// File: rtl/tt_um_example_core.sv
// Tiny Tapeout tile: 8-bit loadable up/down counter with wrap detection,
// plus an 8-bit PWM generator whose duty is written from the data bus.
module tt_um_example_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] cnt;
  logic [7:0] duty;
  logic [7:0] phase;
  logic       wrap_p;
  logic       wrap_s;

  logic load;
  logic count_en;
  logic dir;
  logic duty_wr;
  logic step_wrap;
  logic pwm;

  assign load     = uio_in[0];
  assign count_en = uio_in[1];
  assign dir      = uio_in[2];
  assign duty_wr  = uio_in[3];

  // A wrap only happens on a real count step, which load suppresses.
  assign step_wrap = count_en && !load &&
                     ((dir && (cnt == 8'hFF)) || (!dir && (cnt == 8'h00)));

  // rst_n keeps its TT name but is a synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt    <= 8'h00;
      duty   <= 8'h00;
      phase  <= 8'h00;
      wrap_p <= 1'b0;
      wrap_s <= 1'b0;
    end else if (ena) begin
      if (load) begin
        cnt <= ui_in;
      end else if (count_en) begin
        cnt <= dir ? cnt + 8'd1 : cnt - 8'd1;
      end

      wrap_p <= step_wrap;

      if (load) begin
        wrap_s <= 1'b0;
      end else if (step_wrap) begin
        wrap_s <= 1'b1;
      end

      if (duty_wr) begin
        duty <= ui_in;
      end

      phase <= phase + 8'd1;
    end
  end

  assign pwm = (phase < duty);

  assign uo_out  = cnt;
  assign uio_out = {wrap_s, (cnt == 8'h00), wrap_p, pwm, 4'b0000};
  assign uio_oe  = 8'hF0;

  // Upper strobe bits are reserved and intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_example_core.sv
// Directed self-checking bench for tt_um_example_core: reset, counting,
// wrap flags, PWM duty, enable gating and load/count priority.
module tb_tt_um_example_core;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total;
  int bad;

  tt_um_example_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ena    = 1'($urandom_range(0, 1));
      ui_in  = 8'($urandom_range(0, 255));
      uio_in = 8'($urandom_range(0, 255));
      tick();
    end
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_uo_out got=%h want=00", uo_out);
    end
    total++;
    if (uio_out !== 8'h40) begin
      bad++;
      $display("[TB] FAIL reset_uio_out got=%h want=40", uio_out);
    end
    total++;
    if (uio_oe !== 8'hF0) begin
      bad++;
      $display("[TB] FAIL reset_uio_oe got=%h want=F0", uio_oe);
    end
  endtask

  task automatic test_load_count_up();
    logic [7:0] exp_cnt [4];
    logic [7:0] exp_uio [4];
    exp_cnt = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_uio = '{8'h00, 8'h00, 8'hE0, 8'h80};
    ena    = 1'b1;
    ui_in  = 8'hFD;
    uio_in = 8'h01;
    tick();
    total++;
    if (uo_out !== 8'hFD || uio_out !== 8'h00) begin
      bad++;
      $display("[TB] FAIL load_fd got=%h/%h want=FD/00", uo_out, uio_out);
    end
    uio_in = 8'h06;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (uo_out !== exp_cnt[i] || uio_out !== exp_uio[i]) begin
        bad++;
        $display("[TB] FAIL count_up_%0d got=%h/%h want=%h/%h",
                 i, uo_out, uio_out, exp_cnt[i], exp_uio[i]);
      end
    end
  endtask

  task automatic test_count_down_clear();
    uio_in = 8'h02;
    tick();
    total++;
    if (uo_out !== 8'h00 || uio_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL down_to_00 got=%h/%h want=00/C0", uo_out, uio_out);
    end
    tick();
    total++;
    if (uo_out !== 8'hFF || uio_out !== 8'hA0) begin
      bad++;
      $display("[TB] FAIL down_wrap_ff got=%h/%h want=FF/A0", uo_out, uio_out);
    end
    ui_in  = 8'h10;
    uio_in = 8'h01;
    tick();
    total++;
    if (uo_out !== 8'h10 || uio_out !== 8'h00) begin
      bad++;
      $display("[TB] FAIL load_clears_sticky got=%h/%h want=10/00", uo_out, uio_out);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties [4];
    int         want   [4];
    int         highs;
    duties = '{8'h40, 8'h00, 8'hFF, 8'h80};
    want   = '{64, 0, 255, 128};
    for (int d = 0; d < 4; d++) begin
      ui_in  = duties[d];
      uio_in = 8'h08;
      tick();
      uio_in = 8'h00;
      highs  = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        if (uio_out[4] === 1'b1) highs++;
      end
      total++;
      if (highs != want[d]) begin
        bad++;
        $display("[TB] FAIL pwm_duty_%h high_cycles got=%0d want=%0d",
                 duties[d], highs, want[d]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] exp_uio;
    // Mid-operation reset puts phase at a known 0.
    rst_n = 1'b1;
    tick();
    rst_n  = 1'b0;
    ui_in  = 8'h0B;
    uio_in = 8'h08;
    tick();
    ui_in  = 8'h20;
    uio_in = 8'h01;
    tick();
    total++;
    if (uo_out !== 8'h20 || uio_out !== 8'h10) begin
      bad++;
      $display("[TB] FAIL gate_setup got=%h/%h want=20/10", uo_out, uio_out);
    end
    ena    = 1'b0;
    ui_in  = 8'h99;
    uio_in = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (uo_out !== 8'h20 || uio_out !== 8'h10 || uio_oe !== 8'hF0) begin
        bad++;
        $display("[TB] FAIL gate_frozen_%0d got=%h/%h/%h want=20/10/F0",
                 i, uo_out, uio_out, uio_oe);
      end
    end
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h06;
    // Phase resumes at 3; pwm drops once phase reaches duty 0x0B.
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_uio = ((3 + i) < 11) ? 8'h10 : 8'h00;
      total++;
      if (uo_out !== 8'(8'h21 + i) || uio_out !== exp_uio) begin
        bad++;
        $display("[TB] FAIL gate_resume_%0d got=%h/%h want=%h/%h",
                 i, uo_out, uio_out, 8'(8'h21 + i), exp_uio);
      end
    end
  endtask

  task automatic test_priority();
    int highs;
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    tick();
    uio_in = 8'h06;
    tick();
    total++;
    if (uo_out !== 8'h00 || (uio_out & 8'hEF) !== 8'hE0) begin
      bad++;
      $display("[TB] FAIL prio_setup_wrap got=%h/%h want=00/E0", uo_out, uio_out & 8'hEF);
    end
    ui_in  = 8'h33;
    uio_in = 8'h0F;
    tick();
    total++;
    if (uo_out !== 8'h33 || (uio_out & 8'hEF) !== 8'h00) begin
      bad++;
      $display("[TB] FAIL prio_load_wins got=%h/%h want=33/00", uo_out, uio_out & 8'hEF);
    end
    uio_in = 8'h00;
    highs  = 0;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (uio_out[4] === 1'b1) highs++;
    end
    total++;
    if (highs != 51 || uo_out !== 8'h33) begin
      bad++;
      $display("[TB] FAIL prio_duty_33 high_cycles got=%0d cnt=%h want=51 cnt=33", highs, uo_out);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_load_count_up();
    test_count_down_clear();
    test_pwm();
    test_enable_gating();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_example_core.md
Name: tt_um_example_core

Overview:
- Tiny Tapeout user tile: an 8-bit loadable up/down counter with wrap detection, plus an 8-bit PWM generator whose duty is programmable from the dedicated inputs.
- Sits directly behind the standard TT tile pins; no sub-blocks are required.
- ui_in is the data bus, uio_in[3:0] are control strobes, uio[7:4] are status outputs, and uo_out shows the counter value.

Parameters:
- None; all widths are fixed at 8 bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset. The TT port name is kept, but the reset is synchronous and active-high: rst_n=1 at a rising clk edge resets all state.
- ena  input  1  tile enable; when 0, all state holds and outputs stay driven.
- ui_in  input  8  data bus, used as the load value and the duty value.
- uio_in  input  8  [0]=load, [1]=count_en, [2]=dir (1=up, 0=down), [3]=duty_wr; [7:4] are ignored.
- uo_out  output  8  current counter value.
- uio_out  output  8  [3:0]=0, [4]=pwm, [5]=wrap pulse, [6]=zero flag, [7]=sticky wrap flag.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Registers: cnt[7:0], duty[7:0], phase[7:0], wrap_p, wrap_s.
- Reset (rst_n=1 at an edge) forces every register to 0, overriding ena and every control input. Outputs after reset: uo_out=0x00, uio_out=0x40 (zero flag set, pwm=0), uio_oe=0xF0.
- ena=0: no register changes. Outputs keep reflecting the held state.
- With ena=1, each edge does the following:
  - Counter: if load=1, cnt<=ui_in; load has priority over counting. Else if count_en=1, cnt<=cnt+1 (dir=1) or cnt-1 (dir=0), modulo 256. Else cnt holds.
  - wrap_p is set to 1 for exactly one cycle when a count step goes 0xFF->0x00 (up) or 0x00->0xFF (down). It is 0 on a load cycle and on all other cycles. It is registered, so it is visible in the same cycle the new cnt is visible.
  - wrap_s: set with wrap_p. Cleared by load (load wins over a simultaneous wrap, which cannot occur anyway since load blocks counting). Otherwise it holds.
  - duty_wr=1: duty<=ui_in. This is independent of load; both may occur in the same cycle with the same ui_in.
  - phase<=phase+1 every enabled cycle, wrapping 0xFF->0x00.
- Combinational outputs:
  - uo_out=cnt.
  - zero flag: uio_out[6] = (cnt==0).
  - pwm: uio_out[4] = (phase < duty), unsigned compare. duty=0 gives constant 0. duty=0x80 gives 128 high of 256. duty=0xFF gives 255 high of 256.
  - uio_out[5]=wrap_p; uio_out[7]=wrap_s; uio_out[3:0]=0.
- Latency: one clock from a control strobe to the visible register effect. There is no handshake; strobes are sampled every enabled edge (level-sensitive, so a held count_en counts every cycle).
- Reset mid-operation: state is cleared at the next edge. Counting and PWM resume from 0 the cycle after rst_n drops.

Test Plan:
- Reset: rst_n=1 for 2 cycles with random inputs -> uo_out=0x00, uio_out=0x40, uio_oe=0xF0.
- Load and count up: ui_in=0xFD, load=1 for 1 cycle, then count_en=1, dir=1 for 4 cycles -> uo_out sequence FD, FE, FF, 00, 01. uio[5]=1 only while uo_out=00. uio[7] stays 1 afterwards. uio[6]=1 only at 00.
- Count down and clear: from 0x01 with dir=0 for 2 cycles -> 00, FF, with the wrap pulse at FF. A later load of 0x10 -> uo_out=0x10 and uio[7]=0.
- PWM: duty_wr with ui_in=0x40, then 256 enabled cycles -> uio[4] high exactly 64 cycles. duty 0x00 -> 0 high cycles. duty 0xFF -> 255 high cycles.
- Enable gating: ena=0 with load=1 and count_en=1 for 10 cycles -> uo_out, phase and pwm pattern all frozen. Re-asserting ena resumes counting from the held value.
- Priority: load=1 and count_en=1 together with ui_in=0x33 -> uo_out=0x33 (no increment); simultaneous duty_wr sets duty=0x33.
